ctrl_seq: RTL

- Sequenced control unit for the 9-bit ISA core; the next generation of the combinational control decoder.
- Decodes the fetched instruction and drives the program counter, register file and data memory.
- Adds a run/stall/halt state machine, parametrised load latency, a flag-qualified branch, and a sticky done handshake.
- Sits between instruction ROM and fetch unit, register file and data memory.

---
 rtl/ctrl_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Sequenced control unit for the 9-bit ISA core: decode plus run/load-wait/done FSM.
// Optional build macro CTRL_SEQ_RETIRE_CNT_EN adds the retired-instruction counter.
module ctrl_seq #(
    parameter int INSTR_W  = 9,
    parameter int PC_W     = 10,
    parameter int BR_IDX_W = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               ZeroFlag,
    output logic               PcEn,
    output logic               BranchTaken,
    output logic [PC_W-1:0]    PCTargIdx,
    output logic               RegWrEn,
    output logic               MemWrEn,
    output logic               LoadInst,
    output logic               Stall,
    output logic               Ack,
    output logic [CNT_W-1:0]   RetireCnt
);
    // state  | meaning
    // IDLE   | waiting for Start after reset
    // RUN    | one instruction decoded and executed per cycle
    // LWAIT  | data-memory read in flight, PC held
    // DONE   | HALT retired, Ack held until Start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LWAIT, S_DONE} state_t;
    typedef enum logic [2:0] {OP_ALU, OP_CMP, OP_STORE, OP_LOAD, OP_BR, OP_HALT} op_t;

    localparam int LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    op_t                op;
    logic [4:0]         opc;
    logic [BR_IDX_W-1:0] br_idx;
    logic               instr_unused;

    assign opc          = Instruction[INSTR_W-1 -: 5];
    assign br_idx       = Instruction[3 -: BR_IDX_W];
    assign instr_unused = ^Instruction;

    always_comb begin
        op = OP_ALU;
        if (opc == 5'b11111)           op = OP_HALT;
        else if (opc[4:1] == 4'b1111)  op = OP_BR;
        else if (opc[4:1] == 4'b1110)  op = OP_CMP;
        else if (opc == 5'b11011)      op = OP_STORE;
        else if (opc == 5'b11010)      op = OP_LOAD;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PcEn        = 1'b0;
        BranchTaken = 1'b0;
        PCTargIdx   = '0;
        RegWrEn     = 1'b0;
        MemWrEn     = 1'b0;
        LoadInst    = 1'b0;
        Stall       = 1'b0;
        case (state_q)
            S_IDLE: if (Start) state_d = S_RUN;
            S_RUN: begin
                case (op)
                    OP_ALU: begin
                        RegWrEn = 1'b1;
                        PcEn    = 1'b1;
                    end
                    OP_CMP: PcEn = 1'b1;
                    OP_STORE: begin
                        MemWrEn = 1'b1;
                        PcEn    = 1'b1;
                    end
                    OP_BR: begin
                        PcEn = 1'b1;
                        if (ZeroFlag) begin
                            BranchTaken = 1'b1;
                            PCTargIdx   = PC_W'(br_idx);
                        end
                    end
                    OP_LOAD: begin
                        LoadInst = 1'b1;
                        Stall    = 1'b1;
                        cnt_d    = LAT_W'(LOAD_LAT - 1);
                        state_d  = S_LWAIT;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_LWAIT: begin
                LoadInst = 1'b1;
                if (cnt_q != '0) begin
                    Stall = 1'b1;
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    RegWrEn = 1'b1;
                    PcEn    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: if (Start) state_d = S_RUN;
        endcase
    end

    // Ack is a flop so it rises on the edge entering DONE and drops on the Start edge.
    assign ack_d = (state_d == S_DONE);
    assign Ack   = ack_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q, retire_d;

    // HALT never raises PcEn, so it is counted on its way into DONE.
    always_comb begin
        retire_d = retire_q;
        if (PcEn || (state_q == S_RUN && op == OP_HALT))
            retire_d = retire_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) retire_q <= '0;
        else          retire_q <= retire_d;
    end

    assign RetireCnt = retire_q;
`else
    assign RetireCnt = '0;
`endif
endmodule
